ft6_write_burst: RTL

- Parametrised FT601 245-synchronous write engine.
- Moves words from a first-word-fall-through (FWFT) FIFO to the FT601 bus in bounded bursts, with per-word byte enables.
- Guarantees no loss or duplication when ft6_txe_n deasserts mid-burst by holding the unaccepted word in its output register.
- Sits between the acquisition FIFO and the FT601 pins in the ft6_clk domain.

---
 rtl/ft6_pkg.sv | 21 ++
 rtl/ft6_write_burst.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ft6_pkg.sv
// Shared FT601 write-engine types, bus limits and width helpers.
package ft6_pkg;

   localparam int unsigned FT6_DATA_W_16     = 16;
   localparam int unsigned FT6_DATA_W_32     = 32;
   localparam int unsigned FT6_MAX_BURST_MAX = 65535;
   localparam int unsigned FT6_SETTLE_MAX    = 15;
   localparam int unsigned FT6_BURST_CNT_W   = $clog2(FT6_MAX_BURST_MAX + 1);
   localparam int unsigned FT6_SETTLE_W      = $clog2(FT6_SETTLE_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WRITE  = 2'd2
   } ft6_state_e;

   function automatic int unsigned be_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/ft6_write_burst.sv
// FT601 245-synchronous write engine: drains an FWFT FIFO onto the FT601 bus in
// bounded bursts, holding any refused word until it can be re-presented.
module ft6_write_burst
   import ft6_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned BE_W       = be_width(DATA_W),
   parameter int unsigned MAX_BURST  = 1024,
   parameter int unsigned TXE_SETTLE = 1,
   parameter int unsigned CNT_W      = 32
) (
   input  logic              ft6_clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              ft6_txe_n,
   output logic [DATA_W-1:0] ft6_data,
   output logic [BE_W-1:0]   ft6_be,
   output logic              ft6_wr_n,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic [BE_W-1:0]   fifo_be,
   output logic              fifo_rd_en,
   output logic [CNT_W-1:0]  words_sent,
   output logic              busy
);

   localparam int unsigned               BURST_CMP_W = FT6_BURST_CNT_W + 1;
   localparam logic [BURST_CMP_W-1:0]    BURST_LAST  = BURST_CMP_W'(MAX_BURST);
   localparam logic [FT6_SETTLE_W-1:0]   SETTLE_INIT = FT6_SETTLE_W'(TXE_SETTLE);
   localparam bit                        SKIP_SETTLE = (TXE_SETTLE == 0);

   // Reject illegal parameterisations at elaboration.
   if (DATA_W != FT6_DATA_W_16 && DATA_W != FT6_DATA_W_32) begin : g_bad_data_w
      $error("ft6_write_burst: DATA_W must be 16 or 32");
   end
   if (MAX_BURST < 1 || MAX_BURST > FT6_MAX_BURST_MAX) begin : g_bad_burst
      $error("ft6_write_burst: MAX_BURST out of range");
   end
   if (TXE_SETTLE > FT6_SETTLE_MAX) begin : g_bad_settle
      $error("ft6_write_burst: TXE_SETTLE out of range");
   end

   ft6_state_e                 state_q, state_d;
   logic [DATA_W-1:0]          data_q, data_d;
   logic [BE_W-1:0]            be_q, be_d;
   logic                       vld_q, vld_d;
   logic                       wr_n_q, wr_n_d;
   logic [FT6_BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [FT6_SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
   logic [CNT_W-1:0]           words_q, words_d;
   logic                       accepted, at_limit, stop, pop;

   assign accepted = ~wr_n_q & ~ft6_txe_n;
   assign at_limit = ({1'b0, burst_cnt_q} + BURST_CMP_W'(1)) == BURST_LAST;
   assign stop     = ft6_txe_n | ~enable | (accepted & at_limit);
   // A pop refills the holding register only when it is free or being accepted now.
   assign pop      = (state_q == ST_WRITE) & ~stop & ~fifo_empty & (~vld_q | accepted);

   always_ff @(posedge ft6_clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (enable && !ft6_txe_n && (vld_q || !fifo_empty))
               state_d = SKIP_SETTLE ? ST_WRITE : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (ft6_txe_n)                                  state_d = ST_IDLE;
            else if (settle_cnt_q == FT6_SETTLE_W'(1))      state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (stop || !vld_d) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d       = data_q;
      be_d         = be_q;
      vld_d        = vld_q;
      wr_n_d       = 1'b1;
      burst_cnt_d  = burst_cnt_q;
      settle_cnt_d = settle_cnt_q;
      words_d      = words_q;
      if (accepted) begin
         words_d     = words_q + CNT_W'(1);
         burst_cnt_d = burst_cnt_q + FT6_BURST_CNT_W'(1);
      end
      if (pop) begin
         data_d = fifo_data;
         be_d   = fifo_be;
         vld_d  = 1'b1;
      end else if (accepted) begin
         vld_d  = 1'b0;
      end
      unique case (state_q)
         ST_IDLE: begin
            burst_cnt_d = '0;
            if (state_d == ST_SETTLE) settle_cnt_d = SETTLE_INIT;
         end
         ST_SETTLE: begin
            if (!ft6_txe_n) settle_cnt_d = settle_cnt_q - FT6_SETTLE_W'(1);
         end
         ST_WRITE: wr_n_d = ~(vld_d & ~stop);
         default: ;
      endcase
   end

   always_ff @(posedge ft6_clk or posedge rst) begin
      if (rst) begin
         data_q       <= '0;
         be_q         <= '0;
         vld_q        <= 1'b0;
         wr_n_q       <= 1'b1;
         burst_cnt_q  <= '0;
         settle_cnt_q <= '0;
         words_q      <= '0;
      end else begin
         data_q       <= data_d;
         be_q         <= be_d;
         vld_q        <= vld_d;
         wr_n_q       <= wr_n_d;
         burst_cnt_q  <= burst_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         words_q      <= words_d;
      end
   end

   assign ft6_data   = data_q;
   assign ft6_wr_n   = wr_n_q;
   assign ft6_be     = wr_n_q ? '0 : be_q;
   assign fifo_rd_en = pop;
   assign words_sent = words_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
